// File: rtl/c7bifu_pkg.sv
// Shared constants and types for the c7bifu fetch-side blocks.
package c7bifu_pkg;

  localparam int unsigned IBUF_DEPTH = 8;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned FETCH_W    = 64;

  // One instruction buffer slot: the word and the PC it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } ibuf_entry_t;

endpackage

// File: rtl/c7bifu_ibuf_ptr.sv
// Instruction buffer bookkeeping: read/write pointers, occupancy, fetch-ready
// and the sticky overflow flag. Holds no instruction data.
module c7bifu_ibuf_ptr #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    push_num,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] rd_idx,
  output logic [AW-1:0] wr_idx0,
  output logic [AW-1:0] wr_idx1,
  output logic [PW-1:0] count,
  output logic          push_en,
  output logic          ready,
  output logic          ovf
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [PW:0]   free;
  logic          fits;
  logic          pop_en;
  logic [PW-1:0] push_amt;

  // Admission check (a same-cycle pop frees a slot) and next-state pointers.
  always_comb begin
    pop_en   = pop & ~flush;
    free     = (PW+1)'(DEPTH) - {1'b0, count_q} + {{PW{1'b0}}, pop_en};
    fits     = {{(PW-1){1'b0}}, push_num} <= free;
    push_en  = (push_num != 2'd0) & ~flush & fits;
    push_amt = push_en ? {{(PW-2){1'b0}}, push_num} : '0;
    ovf_d    = ovf_q | ((push_num != 2'd0) & ~flush & ~fits);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_en};
      wr_ptr_d = wr_ptr_q + push_amt;
      count_d  = count_q + push_amt - {{(PW-1){1'b0}}, pop_en};
    end
  end

  // Bookkeeping state; cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Index outputs and the fetch gate, which leaves room for two in-flight returns.
  always_comb begin
    rd_idx  = rd_ptr_q[AW-1:0];
    wr_idx0 = wr_ptr_q[AW-1:0];
    wr_idx1 = wr_ptr_q[AW-1:0] + AW'(1);
    count   = count_q;
    ready   = count_q <= PW'(DEPTH - 4);
    ovf     = ovf_q;
  end

endmodule

// File: rtl/c7bifu_ibuf.sv
// Instruction buffer between the icache return stage (ic2) and decode.
// Optional build macro C7BIFU_IBUF_BYPASS_EN: an empty buffer forwards the
// first valid word of the returning packet to decode in the same cycle.
module c7bifu_ibuf
  import c7bifu_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               icu_ifu_data_valid_ic2,
  input  logic [FETCH_W-1:0] icu_ifu_data_ic2,
  input  logic [31:0]        ifu_pc_ic2,
  input  logic               ifu_ibuf_flush,
  output logic               ifu_ibuf_ready,
  output logic               ifu_exu_valid_d,
  output logic [INST_W-1:0]  ifu_exu_inst_d,
  output logic [31:0]        ifu_exu_pc_d,
  input  logic               exu_ifu_ready_d,
  output logic               ifu_ibuf_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  ibuf_entry_t     mem [DEPTH];
  ibuf_entry_t     lo_word, hi_word, w0, w1, head;
  logic [1:0]      push_num;
  logic            push_en;
  logic            pop;
  logic            not_empty;
  logic [AW-1:0]   rd_idx, wr_idx0, wr_idx1;
  logic [AW:0]     count;

  c7bifu_ibuf_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .resetn   (resetn),
    .push_num (push_num),
    .pop      (pop),
    .flush    (ifu_ibuf_flush),
    .rd_idx   (rd_idx),
    .wr_idx0  (wr_idx0),
    .wr_idx1  (wr_idx1),
    .count    (count),
    .push_en  (push_en),
    .ready    (ifu_ibuf_ready),
    .ovf      (ifu_ibuf_ovf)
  );

  // Split the packet into words, choose what gets stored and what decode sees.
  always_comb begin
    lo_word   = '{inst: icu_ifu_data_ic2[31:0],  pc: {ifu_pc_ic2[31:3], 3'b000}};
    hi_word   = '{inst: icu_ifu_data_ic2[63:32], pc: {ifu_pc_ic2[31:3], 3'b100}};
    not_empty = count != '0;
    head      = mem[rd_idx];
    // A packet entered at the upper half (branch target) carries only one word.
    w0        = ifu_pc_ic2[2] ? hi_word : lo_word;
    w1        = hi_word;
    push_num  = !icu_ifu_data_valid_ic2 ? 2'd0 : (ifu_pc_ic2[2] ? 2'd1 : 2'd2);
    pop       = not_empty & exu_ifu_ready_d;
    ifu_exu_valid_d = not_empty;
    ifu_exu_inst_d  = head.inst;
    ifu_exu_pc_d    = head.pc;
`ifdef C7BIFU_IBUF_BYPASS_EN
    if (!not_empty && icu_ifu_data_valid_ic2 && !ifu_ibuf_flush) begin
      ifu_exu_valid_d = 1'b1;
      ifu_exu_inst_d  = w0.inst;
      ifu_exu_pc_d    = w0.pc;
      // Decode took the first word directly; only the remainder is stored.
      if (exu_ifu_ready_d) begin
        push_num = ifu_pc_ic2[2] ? 2'd0 : 2'd1;
        w0       = hi_word;
      end
    end
`endif
  end

  // Instruction storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_idx0] <= w0;
      if (push_num == 2'd2) mem[wr_idx1] <= w1;
    end
  end

endmodule

// File: tb/tb_c7bifu_ibuf.sv
// Self-checking bench for c7bifu_ibuf with a queue-based reference model.
// Honours C7BIFU_IBUF_BYPASS_EN when the build defines it.
module tb_c7bifu_ibuf;
  import c7bifu_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_valid = 1'b0;
  logic [63:0] data = '0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        ibuf_ready;
  logic        valid_d;
  logic [31:0] inst_d;
  logic [31:0] pc_d;
  logic        exu_ready = 1'b0;
  logic        ovf;

  int n_checks = 0;
  int n_fail = 0;
  ibuf_entry_t q[$];
  bit m_ovf = 1'b0;

  c7bifu_ibuf #(
    .DEPTH (DEPTH)
  ) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .icu_ifu_data_valid_ic2 (data_valid),
    .icu_ifu_data_ic2       (data),
    .ifu_pc_ic2             (pc_in),
    .ifu_ibuf_flush         (flush),
    .ifu_ibuf_ready         (ibuf_ready),
    .ifu_exu_valid_d        (valid_d),
    .ifu_exu_inst_d         (inst_d),
    .ifu_exu_pc_d           (pc_d),
    .exu_ifu_ready_d        (exu_ready),
    .ifu_ibuf_ovf           (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive, compare against the model mid-cycle, advance model, clock.
  task automatic step(input logic v, input logic [63:0] d, input logic [31:0] pc,
                      input logic fl, input logic rd);
    ibuf_entry_t lo, hi, exp_out;
    bit exp_v, byp;
    int need;
    data_valid = v; data = d; pc_in = pc; flush = fl; exu_ready = rd;
    lo = '{inst: d[31:0],  pc: {pc[31:3], 3'b000}};
    hi = '{inst: d[63:32], pc: {pc[31:3], 3'b100}};
    byp = 1'b0;
`ifdef C7BIFU_IBUF_BYPASS_EN
    byp = v && !fl && (q.size() == 0);
`endif
    #4;
    exp_v = (q.size() != 0) || byp;
    check("valid", 64'(valid_d), 64'(exp_v));
    check("ready", 64'(ibuf_ready), 64'(q.size() <= DEPTH - 4));
    check("ovf", 64'(ovf), 64'(m_ovf));
    if (exp_v) begin
      exp_out = byp ? (pc[2] ? hi : lo) : q[0];
      check("inst", 64'(inst_d), 64'(exp_out.inst));
      check("pc", 64'(pc_d), 64'(exp_out.pc));
    end
    if (fl) begin
      q.delete();
    end else begin
      if (exp_v && rd && !byp) void'(q.pop_front());
      if (v) begin
        if (byp && rd) begin
          if (!pc[2]) q.push_back(hi);
        end else begin
          need = pc[2] ? 1 : 2;
          if (DEPTH - q.size() >= need) begin
            if (!pc[2]) q.push_back(lo);
            q.push_back(hi);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    @(posedge clk); #1;
    data_valid = 1'b0; flush = 1'b0;
  endtask

  // Asynchronous reset pulse inside a cycle; outputs must clear immediately.
  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    check("rst_valid", 64'(valid_d), 64'(0));
    check("rst_ready", 64'(ibuf_ready), 64'(1));
    check("rst_ovf", 64'(ovf), 64'(0));
    #1;
    resetn = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (q.size() != 0 && cyc < 40) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      cyc++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
    step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [31:0] pc;
    @(posedge clk); #1;
    pulse_reset();

    // Aligned packet, then decode drains both words; low PC bits ignored.
    step(1'b1, 64'hBBBB_BBBB_AAAA_AAAA, 32'h1c00_0000, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    drain();
    step(1'b1, 64'h2222_2222_1111_1111, 32'h1c00_0013, 1'b0, 1'b1);
    drain();

    // Branch target in the upper half: single entry.
    step(1'b1, 64'hDDDD_DDDD_CCCC_CCCC, 32'h1c00_0014, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    drain();

    // Fill with decode stalled: ready drops at 6, 4th fits, 5th overflows.
    for (int i = 0; i < 5; i++)
      step(1'b1, {32'h5000_0000 + 32'(i), 32'h4000_0000 + 32'(i)},
           32'h1c00_1000 + 32'(8 * i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("ovf_set", 64'(m_ovf), 64'(1));
    drain();

    // Mid-operation reset discards contents and clears ovf; push right after.
    step(1'b1, 64'h7777_7777_6666_6666, 32'h1c00_2000, 1'b0, 1'b0);
    pulse_reset();
    step(1'b1, 64'h9999_9999_8888_8888, 32'h1c00_3000, 1'b0, 1'b0);
    drain();

    // Reach count 5, then flush together with push and pop.
    step(1'b1, 64'h0000_0002_0000_0001, 32'h1c00_4000, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0004_0000_0003, 32'h1c00_4008, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0006_0000_0005, 32'h1c00_4014, 1'b0, 1'b0);
    step(1'b1, 64'hEEEE_EEEE_FFFF_FFFF, 32'h1c00_4018, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h0000_0012_0000_0011, 32'h1c00_5000, 1'b0, 1'b1);
    drain();

    // Stream 20 packets with random decode readiness, fetch gated on ready.
    sent = 0;
    cyc = 0;
    pc = 32'h1c00_6000;
    while (sent < 20 && cyc < 400) begin
      if (q.size() <= DEPTH - 4 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) pc = pc + 32'd4;
        step(1'b1, {pc + 32'd4, pc}, pc, 1'b0, 1'($urandom_range(0, 1)));
        pc = {pc[31:3], 3'b000} + 32'd8;
        sent++;
      end else begin
        step(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)));
      end
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'(20));
    drain();
    check("no_ovf", 64'(ovf), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
